tnn_serial_threshold_neuron: RTL and testbench

// - Parametrised sequential successor of the 3-operand threshold neuron (out = a+b >= c).
// - Accumulates N_IN unsigned W-bit operands streamed over valid/ready, compares the exact sum

---
 rtl/tnn_pkg.sv | 19 +
 rtl/tnn_thr_compare.sv | 24 ++
 rtl/tnn_serial_threshold_neuron.sv | 128 ++++++++++++
 tb/tb_tnn_serial_threshold_neuron.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tnn_pkg.sv
// Shared types and helpers for the threshold-neuron family.
// Holds the FSM state encoding, compare-mode constants and the accumulator width rule.
// No logic; imported by the neuron top and its compare sub-module.
package tnn_pkg;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_e;

  localparam int CMP_GE = 0;
  localparam int CMP_GT = 1;

  // Width that holds n_in * (2^w - 1) exactly, so the running sum can never wrap.
  function automatic int acc_width(input int w, input int n_in);
    return w + $clog2(n_in + 1);
  endfunction

endpackage

// File: rtl/tnn_thr_compare.sv
// Unsigned sum-vs-threshold comparator, ACC_W bits wide.
// Latency: combinational (0 cycles).
// Backpressure: none, pure function of its inputs.
module tnn_thr_compare
  import tnn_pkg::*;
#(
  parameter int ACC_W  = 5,
  parameter int CMP_GT = 0
) (
  input  logic [ACC_W-1:0] i_sum,
  input  logic [ACC_W-1:0] i_thr,
  output logic             o_fire
);

  // Strict mode never fires at thr = max; inclusive mode always fires at thr = 0.
  generate
    if (CMP_GT != CMP_GE) begin : g_gt
      assign o_fire = (i_sum > i_thr);
    end else begin : g_ge
      assign o_fire = (i_sum >= i_thr);
    end
  endgenerate

endmodule

// File: rtl/tnn_serial_threshold_neuron.sv
// Serial threshold neuron: sums N_IN streamed operands and fires if the sum beats a threshold.
// Latency: decision valid the cycle after the last operand is accepted.
// Backpressure: decision held stable until out_ready; no operands accepted while holding.
module tnn_serial_threshold_neuron
  import tnn_pkg::*;
#(
  parameter  int W      = 3,
  parameter  int N_IN   = 2,
  parameter  int CMP_GT = 0,
  localparam int ACC_W  = acc_width(W, N_IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             thr_load,
  input  logic [ACC_W-1:0] thr_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_bit,
  output logic [ACC_W-1:0] out_sum
);

  localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_IN - 1);

  state_e           r_state;
  state_e           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic [ACC_W-1:0] r_shadow_thr;
  logic [ACC_W-1:0] r_active_thr;
  logic [ACC_W-1:0] r_out_sum;
  logic             r_out_bit;

  logic             w_in_ready;
  logic             w_out_valid;
  logic             w_accept;
  logic             w_first;
  logic             w_last;
  logic [ACC_W-1:0] w_sum;
  logic [ACC_W-1:0] w_frame_thr;
  logic             w_fire;

  assign w_accept = in_valid & w_in_ready;
  assign w_first  = (r_cnt == '0);
  assign w_last   = (r_cnt == LAST_CNT);
  assign w_sum    = r_acc + ACC_W'(in_data);
  // On the first operand the active copy is being loaded this very edge, so read the shadow.
  assign w_frame_thr = w_first ? r_shadow_thr : r_active_thr;

  tnn_thr_compare #(
    .ACC_W  (ACC_W),
    .CMP_GT (CMP_GT)
  ) u_cmp (
    .i_sum  (w_sum),
    .i_thr  (w_frame_thr),
    .o_fire (w_fire)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs; HOLD always costs one bubble before the next frame.
  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      ST_ACCUM: begin
        w_in_ready = 1'b1;
        if (w_accept && w_last) begin
          w_state_nxt = ST_HOLD;
        end
      end
      ST_HOLD: begin
        w_out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = ST_ACCUM;
        end
      end
      default: w_state_nxt = ST_ACCUM;
    endcase
  end

  // Threshold shadowing, accumulation and decision capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc        <= '0;
      r_cnt        <= '0;
      r_shadow_thr <= '0;
      r_active_thr <= '0;
      r_out_sum    <= '0;
      r_out_bit    <= 1'b0;
    end else begin
      if (thr_load) begin
        r_shadow_thr <= thr_data;
      end
      if (w_accept) begin
        if (w_first) begin
          r_active_thr <= r_shadow_thr;
        end
        if (w_last) begin
          r_out_sum <= w_sum;
          r_out_bit <= w_fire;
          r_acc     <= '0;
          r_cnt     <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_bit   = r_out_bit;
  assign out_sum   = r_out_sum;

endmodule

// File: tb/tb_tnn_serial_threshold_neuron.sv
// Bench for the serial threshold neuron: three configurations driven from one sequence.
// Default (W=3,N_IN=2,>=), strict compare (CMP_GT=1) and wide (W=4,N_IN=8).
// Expected sums/decisions come from plain arithmetic on the operands and the loaded threshold.
module tb_tnn_serial_threshold_neuron;

  logic clk;
  logic rst;

  // default instance
  logic       d0_thr_load;
  logic [4:0] d0_thr_data;
  logic       d0_in_valid;
  logic       d0_in_ready;
  logic [2:0] d0_in_data;
  logic       d0_out_valid;
  logic       d0_out_ready;
  logic       d0_out_bit;
  logic [4:0] d0_out_sum;

  // strict-compare instance
  logic       g_thr_load;
  logic [4:0] g_thr_data;
  logic       g_in_valid;
  logic       g_in_ready;
  logic [2:0] g_in_data;
  logic       g_out_valid;
  logic       g_out_ready;
  logic       g_out_bit;
  logic [4:0] g_out_sum;

  // wide instance
  logic       w4_thr_load;
  logic [7:0] w4_thr_data;
  logic       w4_in_valid;
  logic       w4_in_ready;
  logic [3:0] w4_in_data;
  logic       w4_out_valid;
  logic       w4_out_ready;
  logic       w4_out_bit;
  logic [7:0] w4_out_sum;

  int checks = 0;
  int errors = 0;
  int m_shadow = 0;   // model of the threshold the next frame of the default instance will use

  tnn_serial_threshold_neuron #(.W(3), .N_IN(2), .CMP_GT(0)) u_d0 (
    .clk(clk), .rst(rst), .thr_load(d0_thr_load), .thr_data(d0_thr_data),
    .in_valid(d0_in_valid), .in_ready(d0_in_ready), .in_data(d0_in_data),
    .out_valid(d0_out_valid), .out_ready(d0_out_ready), .out_bit(d0_out_bit), .out_sum(d0_out_sum)
  );

  tnn_serial_threshold_neuron #(.W(3), .N_IN(2), .CMP_GT(1)) u_gt (
    .clk(clk), .rst(rst), .thr_load(g_thr_load), .thr_data(g_thr_data),
    .in_valid(g_in_valid), .in_ready(g_in_ready), .in_data(g_in_data),
    .out_valid(g_out_valid), .out_ready(g_out_ready), .out_bit(g_out_bit), .out_sum(g_out_sum)
  );

  tnn_serial_threshold_neuron #(.W(4), .N_IN(8), .CMP_GT(0)) u_w4 (
    .clk(clk), .rst(rst), .thr_load(w4_thr_load), .thr_data(w4_thr_data),
    .in_valid(w4_in_valid), .in_ready(w4_in_ready), .in_data(w4_in_data),
    .out_valid(w4_out_valid), .out_ready(w4_out_ready), .out_bit(w4_out_bit), .out_sum(w4_out_sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load0(input int t);
    d0_thr_load = 1'b1;
    d0_thr_data = 5'(t);
    tick();
    d0_thr_load = 1'b0;
    m_shadow = t;
  endtask

  // One frame on the default instance; rnd adds idle gaps, threshold writes and out_ready noise.
  task automatic frame0(input int a, input int b, input bit rnd, input int hold);
    int ops[2];
    int k;
    int guard;
    int thr_f;
    int s;
    int td;
    bit v;
    bit tl;
    bit eb;
    ops[0] = a;
    ops[1] = b;
    k = 0;
    guard = 0;
    thr_f = 0;
    while (k < 2) begin
      chk("accum_in_ready", 32'(d0_in_ready), 32'd1);
      chk("accum_out_valid", 32'(d0_out_valid), 32'd0);
      v  = (!rnd || guard > 20) ? 1'b1 : ($urandom_range(0, 2) != 0);
      tl = rnd && ($urandom_range(0, 3) == 0);
      td = int'($urandom_range(0, 31));
      d0_in_valid  = v;
      d0_in_data   = v ? 3'(ops[k]) : 3'($urandom_range(0, 7));
      d0_thr_load  = tl;
      d0_thr_data  = 5'(td);
      d0_out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      if (v && k == 0) thr_f = m_shadow;
      if (v) k++;
      if (tl) m_shadow = td;
      guard++;
      tick();
    end
    d0_in_valid  = 1'b0;
    d0_thr_load  = 1'b0;
    d0_out_ready = 1'b0;
    s  = a + b;
    eb = (s >= thr_f);
    for (int i = 0; i < hold; i++) begin
      chk("hold_out_valid", 32'(d0_out_valid), 32'd1);
      chk("hold_out_sum", 32'(d0_out_sum), 32'(s));
      chk("hold_out_bit", 32'(d0_out_bit), 32'(eb));
      chk("hold_in_ready", 32'(d0_in_ready), 32'd0);
      d0_in_valid = 1'($urandom_range(0, 1));
      d0_in_data  = 3'($urandom_range(0, 7));
      tl = rnd && ($urandom_range(0, 2) == 0);
      td = int'($urandom_range(0, 31));
      d0_thr_load = tl;
      d0_thr_data = 5'(td);
      if (tl) m_shadow = td;
      tick();
      d0_thr_load = 1'b0;
    end
    chk("out_valid", 32'(d0_out_valid), 32'd1);
    chk("out_sum", 32'(d0_out_sum), 32'(s));
    chk("out_bit", 32'(d0_out_bit), 32'(eb));
    chk("out_in_ready", 32'(d0_in_ready), 32'd0);
    // release together with an operand that must not be taken in the release cycle
    d0_out_ready = 1'b1;
    d0_in_valid  = 1'b1;
    d0_in_data   = 3'($urandom_range(0, 7));
    tick();
    d0_out_ready = 1'b0;
    d0_in_valid  = 1'b0;
  endtask

  task automatic gframe(input int a, input int b, input int t);
    int s;
    g_thr_load = 1'b1;
    g_thr_data = 5'(t);
    tick();
    g_thr_load = 1'b0;
    g_in_valid = 1'b1;
    g_in_data  = 3'(a);
    tick();
    g_in_data  = 3'(b);
    tick();
    g_in_valid = 1'b0;
    s = a + b;
    chk("gt_out_valid", 32'(g_out_valid), 32'd1);
    chk("gt_out_sum", 32'(g_out_sum), 32'(s));
    chk("gt_out_bit", 32'(g_out_bit), 32'(s > t));
    g_out_ready = 1'b1;
    tick();
    g_out_ready = 1'b0;
    chk("gt_in_ready", 32'(g_in_ready), 32'd1);
  endtask

  task automatic wframe(input int t, input bit rnd_ops);
    int s;
    int v;
    s = 0;
    w4_thr_load = 1'b1;
    w4_thr_data = 8'(t);
    tick();
    w4_thr_load = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("w4_accum_valid", 32'(w4_out_valid), 32'd0);
      v = rnd_ops ? int'($urandom_range(0, 15)) : 15;
      s += v;
      w4_in_valid = 1'b1;
      w4_in_data  = 4'(v);
      tick();
    end
    w4_in_valid = 1'b0;
    chk("w4_out_valid", 32'(w4_out_valid), 32'd1);
    chk("w4_out_sum", 32'(w4_out_sum), 32'(s));
    chk("w4_out_bit", 32'(w4_out_bit), 32'(s >= t));
    w4_out_ready = 1'b1;
    tick();
    w4_out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    d0_thr_load = 1'b0; d0_thr_data = '0; d0_in_valid = 1'b0; d0_in_data = '0; d0_out_ready = 1'b0;
    g_thr_load  = 1'b0; g_thr_data  = '0; g_in_valid  = 1'b0; g_in_data  = '0; g_out_ready  = 1'b0;
    w4_thr_load = 1'b0; w4_thr_data = '0; w4_in_valid = 1'b0; w4_in_data = '0; w4_out_ready = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(d0_in_ready), 32'd1);
    chk("rst_out_valid", 32'(d0_out_valid), 32'd0);
    chk("rst_out_bit", 32'(d0_out_bit), 32'd0);
    chk("rst_out_sum", 32'(d0_out_sum), 32'd0);
    chk("rst_gt_in_ready", 32'(g_in_ready), 32'd1);
    chk("rst_w4_out_valid", 32'(w4_out_valid), 32'd0);
    rst = 1'b0;
    m_shadow = 0;

    // thr=0 after reset, inclusive compare fires even on a zero sum
    frame0(0, 0, 1'b0, 0);

    // basic frames at thr=4
    load0(4);
    frame0(3, 1, 1'b0, 0);
    frame0(2, 1, 1'b0, 0);

    // backpressure: decision held 5 cycles with operand pulses ignored
    frame0(5, 6, 1'b0, 5);

    // threshold written on the first operand's cycle belongs to the next frame
    load0(2);
    d0_in_valid = 1'b1; d0_in_data = 3'd1; d0_thr_load = 1'b1; d0_thr_data = 5'd5;
    tick();
    d0_thr_load = 1'b0; d0_in_data = 3'd1;
    tick();
    d0_in_valid = 1'b0;
    chk("thr_timing_sum", 32'(d0_out_sum), 32'd2);
    chk("thr_timing_bit", 32'(d0_out_bit), 32'(2 >= 2));
    d0_out_ready = 1'b1;
    tick();
    d0_out_ready = 1'b0;
    m_shadow = 5;
    frame0(2, 2, 1'b0, 0);

    // exhaustive single-edge equivalent of the combinational a+b>=c neuron
    for (int c = 0; c < 8; c++) begin
      load0(c);
      for (int a = 0; a < 8; a++) begin
        for (int b = 0; b < 8; b++) begin
          frame0(a, b, 1'b0, 0);
        end
      end
    end

    // randomized frames with gaps, threshold churn and random hold lengths
    for (int n = 0; n < 60; n++) begin
      frame0(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'b1, int'($urandom_range(0, 3)));
    end

    // strict compare
    gframe(3, 1, 4);
    gframe(7, 7, 4);
    gframe(7, 7, 31);
    gframe(0, 0, 0);
    gframe(3, 2, 4);

    // wide configuration: full-scale sum and its boundary
    wframe(120, 1'b0);
    wframe(121, 1'b0);
    wframe(60, 1'b1);

    // reset in the middle of a frame discards the partial sum and the threshold
    load0(9);
    d0_in_valid = 1'b1; d0_in_data = 3'd7;
    tick();
    d0_in_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk("midrst_in_ready", 32'(d0_in_ready), 32'd1);
    chk("midrst_out_valid", 32'(d0_out_valid), 32'd0);
    chk("midrst_out_bit", 32'(d0_out_bit), 32'd0);
    chk("midrst_out_sum", 32'(d0_out_sum), 32'd0);
    rst = 1'b0;
    m_shadow = 0;
    frame0(1, 1, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
